// File: rtl/pipeline_alu_pkg.sv
// Shared definitions for the MIPS execute stage: decoded ALU op codes,
// multiply/divide iteration count and the md unit state type.
package pipeline_defs;

  localparam int unsigned OP_W      = 5;
  localparam int unsigned MD_CYCLES = 32;

  localparam logic [OP_W-1:0] ALU_ADD   = 5'd0;
  localparam logic [OP_W-1:0] ALU_ADDU  = 5'd1;
  localparam logic [OP_W-1:0] ALU_SUB   = 5'd2;
  localparam logic [OP_W-1:0] ALU_SUBU  = 5'd3;
  localparam logic [OP_W-1:0] ALU_AND   = 5'd4;
  localparam logic [OP_W-1:0] ALU_OR    = 5'd5;
  localparam logic [OP_W-1:0] ALU_XOR   = 5'd6;
  localparam logic [OP_W-1:0] ALU_NOR   = 5'd7;
  localparam logic [OP_W-1:0] ALU_SLT   = 5'd8;
  localparam logic [OP_W-1:0] ALU_SLTU  = 5'd9;
  localparam logic [OP_W-1:0] ALU_SLL   = 5'd10;
  localparam logic [OP_W-1:0] ALU_SRL   = 5'd11;
  localparam logic [OP_W-1:0] ALU_SRA   = 5'd12;
  localparam logic [OP_W-1:0] ALU_SLLV  = 5'd13;
  localparam logic [OP_W-1:0] ALU_SRLV  = 5'd14;
  localparam logic [OP_W-1:0] ALU_SRAV  = 5'd15;
  localparam logic [OP_W-1:0] ALU_LUI   = 5'd16;
  localparam logic [OP_W-1:0] ALU_MFHI  = 5'd17;
  localparam logic [OP_W-1:0] ALU_MFLO  = 5'd18;
  localparam logic [OP_W-1:0] ALU_MULT  = 5'd19;
  localparam logic [OP_W-1:0] ALU_MULTU = 5'd20;
  localparam logic [OP_W-1:0] ALU_DIV   = 5'd21;
  localparam logic [OP_W-1:0] ALU_DIVU  = 5'd22;
  localparam logic [OP_W-1:0] ALU_MTHI  = 5'd23;
  localparam logic [OP_W-1:0] ALU_MTLO  = 5'd24;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } md_state_t;

  // Ops that read or write HI/LO and must wait for the md unit
  function automatic logic is_hilo_op(input logic [OP_W-1:0] op);
    return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU,
                      ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO};
  endfunction

  function automatic logic is_md_start(input logic [OP_W-1:0] op);
    return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  endfunction

endpackage

// File: rtl/pipeline_alu_muldiv.sv
// Iterative 32-step multiply (shift-add) / divide (restoring) on operand
// magnitudes; sign correction and special cases are applied in FIX.
module pipeline_muldiv
  import pipeline_defs::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     rs_val,
  input  logic [31:0]     rt_val,
  output logic            busy,
  output logic            done,
  output logic [31:0]     hi,
  output logic [31:0]     lo
);

  md_state_t   state_q, state_d;
  logic [4:0]  count_q;
  logic        is_div_q, neg_q, neg_r_q, div_zero_q;
  logic [31:0] dividend_q, operand_q, rem_q, quo_q;
  logic [63:0] prod_q;

  logic        signed_op, div_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_fix;

  always_comb begin
    signed_op = (op == ALU_MULT) || (op == ALU_DIV);
    div_op    = (op == ALU_DIV)  || (op == ALU_DIVU);
    a_neg     = signed_op & rs_val[31];
    b_neg     = signed_op & rt_val[31];
    a_mag     = a_neg ? (32'd0 - rs_val) : rs_val;
    b_mag     = b_neg ? (32'd0 - rt_val) : rt_val;
    mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, operand_q} : 33'd0);
    div_shift = {rem_q, quo_q[31]};
    div_diff  = div_shift - {1'b0, operand_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start) state_d = MD_RUN;
      MD_RUN:  if (count_q == '0) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    busy = (state_q != MD_IDLE);
    done = (state_q == MD_FIX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      dividend_q <= '0;
      operand_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      prod_q     <= '0;
    end else if (state_q == MD_IDLE && start) begin
      count_q    <= 5'(MD_CYCLES - 1);
      is_div_q   <= div_op;
      neg_q      <= a_neg ^ b_neg;
      neg_r_q    <= a_neg;
      div_zero_q <= div_op && (rt_val == '0);
      dividend_q <= rs_val;
      operand_q  <= b_mag;
      rem_q      <= '0;
      quo_q      <= a_mag;
      prod_q     <= {32'd0, a_mag};
    end else if (state_q == MD_RUN) begin
      count_q <= count_q - 5'd1;
      if (is_div_q) begin
        // Partial remainder stays below the divisor, so 32 bits suffice
        if (!div_diff[32]) begin
          rem_q <= div_diff[31:0];
          quo_q <= {quo_q[30:0], 1'b1};
        end else begin
          rem_q <= div_shift[31:0];
          quo_q <= {quo_q[30:0], 1'b0};
        end
      end else begin
        prod_q <= {mul_sum, prod_q[31:1]};
      end
    end
  end

  always_comb begin
    prod_fix = neg_q ? (64'd0 - prod_q) : prod_q;
    if (!is_div_q) begin
      hi = prod_fix[63:32];
      lo = prod_fix[31:0];
    end else if (div_zero_q) begin
      hi = dividend_q;
      lo = '1;
    end else begin
      hi = neg_r_q ? (32'd0 - rem_q) : rem_q;
      lo = neg_q   ? (32'd0 - quo_q) : quo_q;
    end
  end

endmodule

// File: rtl/pipeline_alu.sv
// MIPS execute stage: single-cycle ALU with registered writeback triple,
// HI/LO registers and an iterative multiply/divide unit.
module pipeline_alu #(
  parameter int unsigned OP_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [OP_W-1:0] in_op,
  input  logic [31:0]     in_rs_val,
  input  logic [31:0]     in_rt_val,
  input  logic [31:0]     in_imm,
  input  logic            in_use_imm,
  input  logic [4:0]      in_shamt,
  input  logic [4:0]      in_rd_index,
  input  logic            in_regwrite,
  output logic            stall,
  output logic [4:0]      alu_rd_index,
  output logic [31:0]     alu_rd_val,
  output logic            alu_regwrite_enable,
  output logic            ovf_trap,
  output logic            md_busy
);
  import pipeline_defs::*;

  logic [31:0] hi_q, lo_q, md_hi, md_lo;
  logic [31:0] op_b, add_res, sub_res, result;
  logic        add_ovf, sub_ovf, ovf, gpr_op;
  logic        fire, trap, write, md_start, md_done;

  always_comb begin
    op_b     = in_use_imm ? in_imm : in_rt_val;
    stall    = in_valid & is_hilo_op(in_op) & md_busy;
    fire     = in_valid & ~stall;
    add_res  = in_rs_val + op_b;
    sub_res  = in_rs_val - op_b;
    add_ovf  = (in_rs_val[31] == op_b[31]) && (add_res[31] != in_rs_val[31]);
    sub_ovf  = (in_rs_val[31] != op_b[31]) && (sub_res[31] != in_rs_val[31]);
    result   = '0;
    ovf      = 1'b0;
    gpr_op   = 1'b1;
    case (in_op)
      ALU_ADD:  begin result = add_res; ovf = add_ovf; end
      ALU_ADDU: result = add_res;
      ALU_SUB:  begin result = sub_res; ovf = sub_ovf; end
      ALU_SUBU: result = sub_res;
      ALU_AND:  result = in_rs_val & op_b;
      ALU_OR:   result = in_rs_val | op_b;
      ALU_XOR:  result = in_rs_val ^ op_b;
      ALU_NOR:  result = ~(in_rs_val | op_b);
      ALU_SLT:  result = {31'd0, $signed(in_rs_val) < $signed(op_b)};
      ALU_SLTU: result = {31'd0, in_rs_val < op_b};
      ALU_SLL:  result = op_b << in_shamt;
      ALU_SRL:  result = op_b >> in_shamt;
      ALU_SRA:  result = $unsigned($signed(op_b) >>> in_shamt);
      ALU_SLLV: result = op_b << in_rs_val[4:0];
      ALU_SRLV: result = op_b >> in_rs_val[4:0];
      ALU_SRAV: result = $unsigned($signed(op_b) >>> in_rs_val[4:0]);
      ALU_LUI:  result = {in_imm[15:0], 16'h0000};
      ALU_MFHI: result = hi_q;
      ALU_MFLO: result = lo_q;
      default:  gpr_op = 1'b0;
    endcase
    trap     = fire & ovf;
    // Index 0 doubles as "no write" for the bypass network
    write    = fire & in_regwrite & (in_rd_index != '0) & gpr_op & ~ovf;
    md_start = fire & is_md_start(in_op);
  end

  pipeline_muldiv u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (in_op),
    .rs_val (in_rs_val),
    .rt_val (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_rd_index        <= '0;
      alu_rd_val          <= '0;
      alu_regwrite_enable <= 1'b0;
      ovf_trap            <= 1'b0;
    end else begin
      alu_rd_index        <= write ? in_rd_index : 5'd0;
      alu_rd_val          <= write ? result : 32'd0;
      alu_regwrite_enable <= write;
      ovf_trap            <= trap;
    end
  end

  // MTHI/MTLO stall while busy, so they never collide with the done write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_done) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else if (fire && in_op == ALU_MTHI) begin
      hi_q <= in_rs_val;
    end else if (fire && in_op == ALU_MTLO) begin
      lo_q <= in_rs_val;
    end
  end

endmodule

// File: tb/tb_pipeline_alu.sv
// Self-checking bench for pipeline_alu: cycle model of the execute stage
// plus directed vectors with literal expectations.
module tb_pipeline_alu;
  import pipeline_defs::*;

  logic        clk, rst_n;
  logic        in_valid, in_use_imm, in_regwrite;
  logic [4:0]  in_op, in_shamt, in_rd_index;
  logic [31:0] in_rs_val, in_rt_val, in_imm;
  logic        stall, alu_regwrite_enable, ovf_trap, md_busy;
  logic [4:0]  alu_rd_index;
  logic [31:0] alu_rd_val;

  int tests = 0;
  int fails = 0;

  pipeline_alu #(.OP_W(5)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_op               (in_op),
    .in_rs_val           (in_rs_val),
    .in_rt_val           (in_rt_val),
    .in_imm              (in_imm),
    .in_use_imm          (in_use_imm),
    .in_shamt            (in_shamt),
    .in_rd_index         (in_rd_index),
    .in_regwrite         (in_regwrite),
    .stall               (stall),
    .alu_rd_index        (alu_rd_index),
    .alu_rd_val          (alu_rd_val),
    .alu_regwrite_enable (alu_regwrite_enable),
    .ovf_trap            (ovf_trap),
    .md_busy             (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void model_alu(input logic [4:0] op, input logic [31:0] a, b, imm,
                                    input logic [4:0] sh, input logic [31:0] hi, lo,
                                    output logic [31:0] r, output logic ovf, output logic gpr);
    longint s;
    r = 32'd0; ovf = 1'b0; gpr = 1'b1;
    case (op)
      ALU_ADD:  begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b;
                      ovf = (s != longint'($signed(r))); end
      ALU_ADDU: r = a + b;
      ALU_SUB:  begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b;
                      ovf = (s != longint'($signed(r))); end
      ALU_SUBU: r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  r = b << sh;
      ALU_SRL:  r = b >> sh;
      ALU_SRA:  r = $unsigned($signed(b) >>> sh);
      ALU_SLLV: r = b << a[4:0];
      ALU_SRLV: r = b >> a[4:0];
      ALU_SRAV: r = $unsigned($signed(b) >>> a[4:0]);
      ALU_LUI:  r = {imm[15:0], 16'h0000};
      ALU_MFHI: r = hi;
      ALU_MFLO: r = lo;
      default:  gpr = 1'b0;
    endcase
  endfunction

  function automatic void model_md(input logic [4:0] op, input logic [31:0] a, b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    longint      p;
    logic [63:0] u;
    hi = 32'd0; lo = 32'd0;
    if (op == ALU_MULT) begin
      p = longint'($signed(a)) * longint'($signed(b));
      {hi, lo} = p;
    end else if (op == ALU_MULTU) begin
      u = {32'd0, a} * {32'd0, b};
      {hi, lo} = u;
    end else if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF; hi = a;
    end else if (op == ALU_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000; hi = 32'd0;
      end else begin
        lo = $signed(a) / $signed(b);
        hi = $signed(a) % $signed(b);
      end
    end else begin
      lo = a / b; hi = a % b;
    end
  endfunction

  logic [31:0] m_hi, m_lo, m_md_hi, m_md_lo, nh, nl, res, opb;
  int          m_cnt, ncnt;
  logic        busy_e, stall_e, acc, ovf_m, gpr_m, wr;
  logic [4:0]  n_idx;
  logic [31:0] n_val;
  logic        n_en, n_trap;

  initial begin
    m_hi = 0; m_lo = 0; m_cnt = 0;
    forever begin
      @(negedge clk); #2;
      n_idx = 0; n_val = 0; n_en = 0; n_trap = 0;
      if (!rst_n) begin
        m_hi = 0; m_lo = 0; m_cnt = 0; nh = 0; nl = 0; ncnt = 0;
      end else begin
        busy_e  = (m_cnt > 0);
        stall_e = in_valid && busy_e &&
                  (in_op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU,
                                 ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO});
        chk("md_busy", md_busy, busy_e);
        chk("stall", stall, stall_e);
        acc = in_valid && !stall_e;
        opb = in_use_imm ? in_imm : in_rt_val;
        model_alu(in_op, in_rs_val, opb, in_imm, in_shamt, m_hi, m_lo, res, ovf_m, gpr_m);
        wr     = acc && in_regwrite && (in_rd_index != 0) && gpr_m && !ovf_m;
        n_trap = acc && ovf_m;
        n_en   = wr;
        n_idx  = wr ? in_rd_index : 5'd0;
        n_val  = wr ? res : 32'd0;
        nh = m_hi; nl = m_lo; ncnt = m_cnt;
        if (m_cnt > 0) begin
          ncnt = m_cnt - 1;
          if (ncnt == 0) begin nh = m_md_hi; nl = m_md_lo; end
        end
        if (acc && in_op == ALU_MTHI) nh = in_rs_val;
        if (acc && in_op == ALU_MTLO) nl = in_rs_val;
        if (acc && in_op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU}) begin
          model_md(in_op, in_rs_val, opb, m_md_hi, m_md_lo);
          ncnt = 33;
        end
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        m_hi = 0; m_lo = 0; m_cnt = 0;
        n_idx = 0; n_val = 0; n_en = 0; n_trap = 0;
      end else begin
        m_hi = nh; m_lo = nl; m_cnt = ncnt;
      end
      chk("rd_index", alu_rd_index, n_idx);
      chk("rd_val", alu_rd_val, n_val);
      chk("regwrite_enable", alu_regwrite_enable, n_en);
      chk("ovf_trap", ovf_trap, n_trap);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [4:0] op, input logic [31:0] rs, rt, imm,
                       input logic ui, input logic [4:0] sh, rd, input logic rw,
                       output int stalls);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rs_val = rs; in_rt_val = rt; in_imm = imm;
    in_use_imm = ui; in_shamt = sh; in_rd_index = rd; in_regwrite = rw;
    stalls = 0;
    #1;
    while (stall && stalls < 100) begin
      stalls++;
      @(negedge clk); #1;
    end
    if (stall) chk("stall_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  int s;

  initial begin
    rst_n = 1'b1; in_valid = 0; in_op = 0; in_rs_val = 0; in_rt_val = 0; in_imm = 0;
    in_use_imm = 0; in_shamt = 0; in_rd_index = 0; in_regwrite = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rd_index", alu_rd_index, 0);
    chk("reset_rd_val", alu_rd_val, 0);
    chk("reset_enable", alu_regwrite_enable, 0);
    chk("reset_trap", ovf_trap, 0);
    chk("reset_busy", md_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 5, 1, s);
    chk("add_ovf_trap", ovf_trap, 1);
    chk("add_ovf_enable", alu_regwrite_enable, 0);
    chk("add_ovf_index", alu_rd_index, 0);
    issue(ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 5, 1, s);
    chk("addu_val", alu_rd_val, 32'h8000_0000);
    chk("addu_index", alu_rd_index, 5);
    chk("addu_enable", alu_regwrite_enable, 1);
    chk("addu_no_trap", ovf_trap, 0);
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 3, 1, s);
    chk("slt_val", alu_rd_val, 1);
    issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 3, 1, s);
    chk("sltu_val", alu_rd_val, 0);
    chk("sltu_enable", alu_regwrite_enable, 1);
    issue(ALU_SRA, 0, 32'h8000_0000, 0, 0, 4, 4, 1, s);
    chk("sra_val", alu_rd_val, 32'hF800_0000);
    issue(ALU_LUI, 0, 0, 32'h0000_1234, 1, 0, 6, 1, s);
    chk("lui_val", alu_rd_val, 32'h1234_0000);

    issue(ALU_SUB,  32'h8000_0000, 32'd1, 0, 0, 0, 2, 1, s);
    issue(ALU_SUB,  32'd5, 32'hDEAD, 32'd3, 1, 0, 2, 1, s);
    issue(ALU_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 11, 1, s);
    issue(ALU_OR,   32'hF0F0_0000, 32'h0000_0F0F, 0, 0, 0, 11, 1, s);
    issue(ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0, 0, 11, 1, s);
    issue(ALU_NOR,  32'h1234_5678, 32'h0000_FFFF, 0, 0, 0, 11, 1, s);
    issue(ALU_SLLV, 32'd35, 32'd1, 0, 0, 0, 12, 1, s);
    issue(ALU_SRLV, 32'd4, 32'h8000_0000, 0, 0, 0, 12, 1, s);
    issue(ALU_SRAV, 32'd4, 32'h8000_0000, 0, 0, 0, 12, 1, s);
    issue(ALU_SLL,  0, 32'd1, 0, 0, 31, 12, 1, s);
    issue(ALU_SRL,  0, 32'hFFFF_FFFF, 0, 0, 28, 12, 1, s);
    issue(ALU_ADD,  32'd1, 32'd2, 0, 0, 0, 0, 1, s);
    issue(ALU_ADDU, 32'd1, 32'd2, 0, 0, 0, 9, 0, s);
    issue(ALU_SUB,  32'hFFFF_FFFB, 32'd3, 0, 0, 0, 13, 1, s);
    issue(ALU_ADD,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 13, 1, s);

    issue(ALU_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, 0, 0, s);
    issue(ALU_MFLO, 0, 0, 0, 0, 0, 8, 1, s);
    chk("mult_stall_cycles", s, 33);
    chk("mult_lo", alu_rd_val, 32'hFFFF_FFEB);
    issue(ALU_MFHI, 0, 0, 0, 0, 0, 9, 1, s);
    chk("mult_hi", alu_rd_val, 32'hFFFF_FFFF);

    issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0, s);
    issue(ALU_MFLO, 0, 0, 0, 0, 0, 8, 1, s);
    chk("div_lo", alu_rd_val, 32'hFFFF_FFFD);
    issue(ALU_MFHI, 0, 0, 0, 0, 0, 9, 1, s);
    chk("div_hi", alu_rd_val, 32'hFFFF_FFFF);

    issue(ALU_DIVU, 32'd5, 32'd0, 0, 0, 0, 0, 0, s);
    issue(ALU_MFLO, 0, 0, 0, 0, 0, 8, 1, s);
    chk("divz_lo", alu_rd_val, 32'hFFFF_FFFF);
    issue(ALU_MFHI, 0, 0, 0, 0, 0, 9, 1, s);
    chk("divz_hi", alu_rd_val, 32'd5);

    issue(ALU_DIVU, 32'd100, 32'd7, 0, 0, 0, 0, 0, s);
    issue(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 0, 0, 0, 1, 1, s);
    chk("or_busy_no_stall", s, 0);
    chk("or_busy_val", alu_rd_val, 32'hFF);
    chk("or_busy_md_busy", md_busy, 1);
    issue(ALU_MFLO, 0, 0, 0, 0, 0, 8, 1, s);
    chk("divu_lo", alu_rd_val, 32'd14);
    issue(ALU_MFHI, 0, 0, 0, 0, 0, 9, 1, s);
    chk("divu_hi", alu_rd_val, 32'd2);

    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, s);
    issue(ALU_MFLO, 0, 0, 0, 0, 0, 8, 1, s);
    chk("divmin_lo", alu_rd_val, 32'h8000_0000);
    issue(ALU_MFHI, 0, 0, 0, 0, 0, 9, 1, s);
    chk("divmin_hi", alu_rd_val, 32'd0);

    issue(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, s);
    issue(ALU_MFHI, 0, 0, 0, 0, 0, 9, 1, s);
    chk("multu_hi", alu_rd_val, 32'hFFFF_FFFE);
    issue(ALU_MFLO, 0, 0, 0, 0, 0, 8, 1, s);
    chk("multu_lo", alu_rd_val, 32'd1);

    issue(ALU_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, s);
    issue(ALU_MFLO, 0, 0, 0, 0, 0, 8, 1, s);
    issue(ALU_MFHI, 0, 0, 0, 0, 0, 9, 1, s);

    issue(ALU_MTHI, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, s);
    issue(ALU_MTLO, 32'h1234_5678, 0, 0, 0, 0, 0, 0, s);
    issue(ALU_MFHI, 0, 0, 0, 0, 0, 9, 1, s);
    chk("mthi_readback", alu_rd_val, 32'hDEAD_BEEF);
    issue(ALU_MFLO, 0, 0, 0, 0, 0, 8, 1, s);
    chk("mtlo_readback", alu_rd_val, 32'h1234_5678);

    issue(ALU_MULT, 32'd3, 32'd5, 0, 0, 0, 0, 0, s);
    for (int i = 1; i <= 9; i++) issue(ALU_ADDU, i, 32'd0, 0, 0, 0, 7, 1, s);
    chk("pre_reset_val", alu_rd_val, 32'd9);
    chk("pre_reset_busy", md_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rd_val", alu_rd_val, 0);
    chk("midreset_enable", alu_regwrite_enable, 0);
    chk("midreset_index", alu_rd_index, 0);
    chk("midreset_busy", md_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(ALU_MFHI, 0, 0, 0, 0, 0, 10, 1, s);
    chk("post_reset_mfhi_stall", s, 0);
    chk("post_reset_mfhi_val", alu_rd_val, 0);
    chk("post_reset_mfhi_en", alu_regwrite_enable, 1);
    issue(ALU_MFLO, 0, 0, 0, 0, 0, 10, 1, s);
    chk("post_reset_mflo_val", alu_rd_val, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at t=%0t, expected to finish", $time);
    $fatal(1);
  end

endmodule
